hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32I core. It generates the `stall` and `branch` (flush) controls consumed by the ID/EX pipeline register, plus PC/IF-ID hold and flush and the EX operand forwarding selects. It tracks multi-cycle redirect flushes and data-memory wait freezes in a small FSM. It keeps saturating hazard performance counters.

---
 rtl/riscv_pipe_pkg.sv | 32 +++
 rtl/fwd_unit.sv | 21 ++
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline hazard types, constants and forwarding helper
package riscv_pipe_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        FREEZE = 2'd2
    } hz_state_e;

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       exmem_we,
        input logic [4:0] exmem_rd,
        input logic       memwb_we,
        input logic [4:0] memwb_rd
    );
        if (exmem_we && exmem_rd != REG_X0 && exmem_rd == rs) begin
            return FWD_EXMEM;
        end else if (memwb_we && memwb_rd != REG_X0 && memwb_rd == rs) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - combinational EX operand forwarding select for both operands
module fwd_unit
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] idex_rs1,
    input  logic [4:0] idex_rs2,
    input  logic       exmem_reg_write,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_reg_write,
    input  logic [4:0] memwb_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    // Pick the youngest in-flight producer of each source register.
    always_comb begin
        fwd_a = fwd_sel(idex_rs1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
        fwd_b = fwd_sel(idex_rs2, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze FSM, forwarding and hazard counters
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       idex_rs1,
    input  logic [4:0]       idex_rs2,
    input  logic             ex_redirect,
    input  logic             exmem_reg_write,
    input  logic [4:0]       exmem_rd,
    input  logic             memwb_reg_write,
    input  logic [4:0]       memwb_rd,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             stall,
    output logic             branch,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hz_state_e        state_q, state_d;
    hz_state_e        ret_q, ret_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
    logic             inc_stall, inc_flush, inc_freeze;
    logic             lu;
    hz_state_e        eff_state;

    fwd_unit u_fwd (
        .idex_rs1        (idex_rs1),
        .idex_rs2        (idex_rs2),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    assign lu = idex_mem_read && (idex_rd != REG_X0) &&
                ((id_use_rs1 && id_rs1 == idex_rd) || (id_use_rs2 && id_rs2 == idex_rd));

    // After a freeze the pipeline resumes whatever it was doing before it.
    assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

    // Next state and pipeline controls: busy > redirect > flush tail > load-use.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        stall      = 1'b0;
        branch     = 1'b0;
        freeze     = 1'b0;
        inc_stall  = 1'b0;
        inc_flush  = 1'b0;
        inc_freeze = 1'b0;
        state_d    = state_q;
        ret_d      = ret_q;
        rem_d      = rem_q;
        if (dmem_busy) begin
            freeze     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            inc_freeze = 1'b1;
            ret_d      = eff_state;
            state_d    = FREEZE;
        end else if (ex_redirect) begin
            branch     = 1'b1;
            ifid_flush = 1'b1;
            inc_flush  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                rem_d   = FLUSH_INIT;
            end else begin
                state_d = RUN;
            end
        end else if (eff_state == FLUSH) begin
            branch     = 1'b1;
            ifid_flush = 1'b1;
            if (rem_q <= 3'd1) begin
                state_d = RUN;
                rem_d   = 3'd0;
            end else begin
                state_d = FLUSH;
                rem_d   = rem_q - 3'd1;
            end
        end else begin
            state_d = RUN;
            if (lu) begin
                stall      = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                inc_stall  = 1'b1;
            end
        end
    end

    // State, return state and flush countdown registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ret_q   <= RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
        end
    end

    // Saturating hazard event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (inc_stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (inc_flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
            if (inc_freeze && freeze_cnt_q != '1) begin
                freeze_cnt_q <= freeze_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
    logic        id_use_rs1, id_use_rs2, idex_mem_read, ex_redirect;
    logic        exmem_reg_write, memwb_reg_write, dmem_busy;

    logic        pc_write, ifid_write, ifid_flush, stall, branch, freeze;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;

    logic        pc_write_s, ifid_write_s, ifid_flush_s, stall_s, branch_s, freeze_s;
    logic [1:0]  fwd_a_s, fwd_b_s;
    logic [1:0]  stall_cnt_s, flush_cnt_s, freeze_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
        .ex_redirect(ex_redirect), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .dmem_busy(dmem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .stall(stall), .branch(branch), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
        .ex_redirect(ex_redirect), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .dmem_busy(dmem_busy),
        .pc_write(pc_write_s), .ifid_write(ifid_write_s), .ifid_flush(ifid_flush_s),
        .stall(stall_s), .branch(branch_s), .freeze(freeze_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s), .freeze_cnt(freeze_cnt_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        idex_mem_read = 0; idex_rd = 0; idex_rs1 = 0; idex_rs2 = 0;
        ex_redirect = 0; exmem_reg_write = 0; exmem_rd = 0;
        memwb_reg_write = 0; memwb_rd = 0; dmem_busy = 0;
    endtask

    task automatic set_lu();
        idex_mem_read = 1; idex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 1;
    endtask

    // ctl packs {pc_write, ifid_write, ifid_flush, stall, branch, freeze}
    task automatic check_ctl(input string tag, input logic [5:0] exp);
        check(tag, {pc_write, ifid_write, ifid_flush, stall, branch, freeze}, exp);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        #2;
        check_ctl("reset_ctl", 6'b110000);
        check("reset_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("reset_cnts", {stall_cnt, flush_cnt, freeze_cnt}, 96'd0);
        tick();
        reset = 0;

        // load-use on rs1
        set_lu();
        #1 check_ctl("lu_stall", 6'b000100);
        tick();
        check("lu_stall_cnt", stall_cnt, 1);
        idex_mem_read = 0;
        #1 check_ctl("lu_after", 6'b110000);

        // load into x0 never stalls; unused rs2 match never stalls
        idex_mem_read = 1; idex_rd = 0; id_rs1 = 0;
        #1 check_ctl("lu_x0", 6'b110000);
        idex_rd = 7; id_rs1 = 5; id_use_rs2 = 0;
        #1 check_ctl("lu_rs2_unused", 6'b110000);
        tick();
        check("lu_x0_cnt", stall_cnt, 1);

        // redirect together with load-use, two-cycle flush
        set_lu(); ex_redirect = 1;
        #1 check_ctl("redir_lu", 6'b111010);
        tick();
        ex_redirect = 0;
        #1 check_ctl("flush_tail", 6'b111010);
        check("flush1_tail_s", {ifid_flush_s, stall_s}, 2'b01);
        clear_inputs();
        tick();
        check_ctl("flush_done", 6'b110000);
        check("redir_flush_cnt", flush_cnt, 1);
        check("redir_stall_cnt", stall_cnt, 1);

        // freeze for 3 cycles in FLUSH with one cycle remaining
        ex_redirect = 1;
        tick();
        ex_redirect = 0; dmem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check_ctl("busy_in_flush", 6'b000001);
            tick();
        end
        dmem_busy = 0;
        #1 check_ctl("flush_resume", 6'b111010);
        tick();
        check_ctl("flush_resume_done", 6'b110000);
        check("freeze_cnt3", freeze_cnt, 3);
        check("flush_cnt2", flush_cnt, 2);
        check("freeze_cnt_sat3", freeze_cnt_s, 3);

        // busy outranks redirect; redirect reconsidered once released
        dmem_busy = 1; ex_redirect = 1;
        #1 check_ctl("busy_over_redir", 6'b000001);
        tick();
        check("busy_redir_flush_cnt", flush_cnt, 2);
        dmem_busy = 0;
        #1 check_ctl("redir_after_busy", 6'b111010);
        tick();
        ex_redirect = 0;
        #1 check_ctl("redir_after_busy_tail", 6'b111010);
        tick();
        check_ctl("redir_after_busy_done", 6'b110000);
        check("flush_cnt3", flush_cnt, 3);
        dmem_busy = 1;
        tick();
        tick();
        dmem_busy = 0;
        check("freeze_cnt6", freeze_cnt, 6);
        check("freeze_cnt_sat_hold", freeze_cnt_s, 3);

        // forwarding
        idex_rs1 = 3; idex_rs2 = 3; exmem_rd = 3; memwb_rd = 3;
        exmem_reg_write = 1; memwb_reg_write = 1;
        #1 check("fwd_exmem", {fwd_a, fwd_b}, 4'b0101);
        exmem_reg_write = 0;
        #1 check("fwd_memwb", {fwd_a, fwd_b}, 4'b1010);
        exmem_reg_write = 1; idex_rs2 = 4;
        #1 check("fwd_mixed", {fwd_a, fwd_b}, 4'b0100);
        idex_rs2 = 3; exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0; idex_rs2 = 0;
        #1 check("fwd_x0", {fwd_a, fwd_b}, 4'b0000);
        clear_inputs();

        // async reset in the middle of a flush
        ex_redirect = 1;
        tick();
        ex_redirect = 0;
        #1 check_ctl("pre_reset_flush", 6'b111010);
        reset = 1;
        #1 check_ctl("async_reset_ctl", 6'b110000);
        check("async_reset_cnts", {stall_cnt, flush_cnt, freeze_cnt}, 96'd0);
        tick();
        reset = 0;
        #1 check_ctl("post_reset_run", 6'b110000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
